// File: rtl/des3_mon_pkg.sv
// Shared types and constants for the des3 output monitor.
// The MISR polynomial is x^64+x^63+x^61+x^60+1. Its feedback taps are
// signature bits 63, 62, 60 and 59.
package des3_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mon_state_t;

  localparam int CNT_W = 16;

  // Feedback tap mask: bits 63, 62, 60, 59.
  localparam logic [63:0] MISR_TAPS = 64'hD800_0000_0000_0000;

  // Fold a 64-bit signature into 16 LED bits by XOR-ing its four quarters.
  function automatic logic [15:0] led_fold(input logic [63:0] s);
    return s[63:48] ^ s[47:32] ^ s[31:16] ^ s[15:0];
  endfunction

endpackage

// File: rtl/des3_mon_misr.sv
// Combinational next state of the 64-bit MISR.
// The register shifts left by one bit. The XOR of the tapped bits enters at
// bit 0, and the incoming result word is then XOR-ed over the whole word.
module des3_mon_misr
  import des3_mon_pkg::*;
(
  input  logic [63:0] sig,
  input  logic [63:0] din,
  output logic [63:0] sig_n
);

  logic fb;

  // Feedback bit is the parity of the tapped signature bits.
  always_comb begin
    fb    = ^(sig & MISR_TAPS);
    sig_n = {sig[62:0], fb} ^ din;
  end

endmodule

// File: rtl/des3_out_monitor.sv
// Output-side monitor for the des3_perf result stream.
//
// A valid shift chain of depth LATENCY follows each block issued during RUN
// through the core's pipeline. When the chain tap is set in RUN, the result
// bus is folded into the MISR signature and the result counter advances.
// The burst ends after BURST_LEN captures.
//
// Optional feature: define DES3_MON_GOLDEN_EN to register pass/fail from a
// comparison of the signature against GOLDEN while the burst is done. When
// the macro is not defined, pass and fail are tied low and no comparator is
// built.
module des3_out_monitor
  import des3_mon_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          LATENCY   = 48,
  parameter int          BURST_LEN = 256,
  parameter logic [63:0] GOLDEN    = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] des_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result_cnt,
  output logic [DATA_W-1:0] signature,
  output logic              pass,
  output logic              fail,
  output logic [15:0]       led
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  mon_state_t          state;
  mon_state_t          state_n;
  logic [LATENCY-1:0]  vchain;
  logic [LATENCY-1:0]  vchain_n;
  logic                issue;
  logic                capture;
  logic                last_capture;
  logic [DATA_W-1:0]   sig_n;

  // A block is tracked only when it is issued during RUN.
  assign issue        = in_valid && (state == RUN);
  assign capture      = vchain[LATENCY-1] && (state == RUN);
  assign last_capture = capture && (result_cnt == LAST_CNT);

  des3_mon_misr u_misr (
    .sig   (signature),
    .din   (des_out),
    .sig_n (sig_n)
  );

  // Valid chain shifted by one position. The loop form keeps LATENCY=1 legal.
  always_comb begin
    vchain_n    = '0;
    vchain_n[0] = issue;
    for (int i = 1; i < LATENCY; i++) begin
      vchain_n[i] = vchain[i-1];
    end
  end

  // Burst sequencing. start is honoured only in IDLE and DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ARM;
      ARM:     state_n = RUN;
      RUN:     if (last_capture) state_n = DONE;
      DONE:    if (start) state_n = ARM;
      default: state_n = IDLE;
    endcase
  end

  // State, valid chain, counter, signature and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vchain     <= '0;
      result_cnt <= '0;
      signature  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      led        <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == ARM) || (state_n == RUN);
      done  <= (state_n == DONE);
      led   <= led_fold(signature);
      if (state == ARM) begin
        // Arming drops anything still in flight from the previous burst.
        vchain     <= '0;
        result_cnt <= '0;
        signature  <= '0;
      end else begin
        vchain <= vchain_n;
        if (capture) begin
          signature  <= sig_n;
          result_cnt <= result_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef DES3_MON_GOLDEN_EN
  // The signature is frozen in DONE, so this comparison is stable for the
  // whole DONE period. The flags clear once the next burst is armed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      pass <= (state == DONE) && (signature == GOLDEN);
      fail <= (state == DONE) && (signature != GOLDEN);
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign pass          = 1'b0;
  assign fail          = 1'b0;
`endif

endmodule

// File: tb/tb_des3_out_monitor.sv
// Directed bench for des3_out_monitor (LATENCY=48, BURST_LEN=4).
// A burst-level model follows issue times in a queue and is compared with
// the DUT outputs on every falling edge. Hand-computed literals pin the
// signatures and the capture latency.
module tb_des3_out_monitor;

  localparam int          LAT  = 48;
  localparam int          BL   = 4;
  localparam logic [63:0] GOLD = 64'h0000_0000_0000_000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] des_out = '0;
  logic        busy, done, pass, fail;
  logic [15:0] result_cnt, led;
  logic [63:0] signature;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  des3_out_monitor #(
    .DATA_W    (64),
    .LATENCY   (LAT),
    .BURST_LEN (BL),
    .GOLDEN    (GOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .des_out    (des_out),
    .busy       (busy),
    .done       (done),
    .result_cnt (result_cnt),
    .signature  (signature),
    .pass       (pass),
    .fail       (fail),
    .led        (led)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Phase: 0 idle, 1 arm, 2 run, 3 done.
  int          cyc = 0;
  int          ph = 0;
  logic [63:0] m_sig = '0;
  int          m_cnt = 0;
  logic [15:0] m_led = '0;
  logic        m_pass = 1'b0;
  logic        m_fail = 1'b0;
  int          issue_q[$];

  function automatic logic [63:0] ref_misr(input logic [63:0] s, input logic [63:0] d);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return ((s << 1) | {63'd0, fb}) ^ d;
  endfunction

  function automatic logic [15:0] ref_fold(input logic [63:0] s);
    return s[63:48] ^ s[47:32] ^ s[31:16] ^ s[15:0];
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] sig_old;
    int          ph_old;
    bit          cap;
    cyc++;
    sig_old = m_sig;
    ph_old  = ph;
    if (!rst_n) begin
      ph = 0; m_sig = '0; m_cnt = 0; m_led = '0; m_pass = 1'b0; m_fail = 1'b0;
      issue_q.delete();
    end else begin
      cap = 1'b0;
      // A block issued at edge n comes out at edge n+LAT.
      while (issue_q.size() > 0 && issue_q[0] + LAT <= cyc) begin
        if (issue_q[0] + LAT == cyc) cap = 1'b1;
        void'(issue_q.pop_front());
      end
      case (ph_old)
        0: if (start) ph = 1;
        1: begin m_sig = '0; m_cnt = 0; issue_q.delete(); ph = 2; end
        2: begin
          if (in_valid) issue_q.push_back(cyc);
          if (cap && m_cnt < BL) begin
            m_sig = ref_misr(m_sig, des_out);
            m_cnt++;
            if (m_cnt == BL) ph = 3;
          end
        end
        default: if (start) ph = 1;
      endcase
      m_led = ref_fold(sig_old);
`ifdef DES3_MON_GOLDEN_EN
      m_pass = (ph_old == 3) && (sig_old == GOLD);
      m_fail = (ph_old == 3) && (sig_old != GOLD);
`else
      m_pass = 1'b0;
      m_fail = 1'b0;
`endif
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  logic [15:0] prev_cnt = '0;
  int          cap1_cyc = -1;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy",       {63'd0, busy},  {63'd0, (ph == 1 || ph == 2)});
      check("done",       {63'd0, done},  {63'd0, (ph == 3)});
      check("result_cnt", {48'd0, result_cnt}, 64'(m_cnt));
      check("signature",  signature, m_sig);
      check("led",        {48'd0, led}, {48'd0, m_led});
      check("pass",       {63'd0, pass}, {63'd0, m_pass});
      check("fail",       {63'd0, fail}, {63'd0, m_fail});
      if (cap1_cyc < 0 && prev_cnt == 16'd0 && result_cnt == 16'd1) cap1_cyc = cyc;
      prev_cnt = result_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_burst();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);   // the ARM cycle has passed; the DUT is now in RUN
  endtask

  task automatic issue(input int n);
    in_valid = 1'b1;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  task automatic wait_cnt(input string name, input logic [15:0] target, input int budget);
    int k = 0;
    while (result_cnt != target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {48'd0, result_cnt}, {48'd0, target});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int first_issue;

    // 1) reset held for three cycles while start and in_valid toggle
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start    = i[0];
      in_valid = ~i[0];
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_cnt",  {48'd0, result_cnt}, 64'd0);
    check("rst_sig",  signature, 64'd0);
    check("rst_led",  {48'd0, led}, 64'd0);
    check("rst_pf",   {62'd0, pass, fail}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2) four blocks, des_out = 1: capture latency, done timing, signature 0xF
    des_out = 64'd1;
    begin_burst();
    first_issue = cyc + 1;
    issue(4);
    wait_done("t2_done_timeout", 100);
    check("t2_latency", 64'(cap1_cyc - first_issue), 64'(LAT));
    check("t2_cnt", {48'd0, result_cnt}, 64'd4);
    check("t2_sig", signature, 64'h0000_0000_0000_000F);
    check("t2_model_sig", m_sig, 64'h0000_0000_0000_000F);
    @(negedge clk);
    check("t2_led", {48'd0, led}, 64'h000F);
`ifdef DES3_MON_GOLDEN_EN
    check("t6_pass", {63'd0, pass}, 64'd1);
    check("t6_fail", {63'd0, fail}, 64'd0);
`else
    check("t6_pf_off", {62'd0, pass, fail}, 64'd0);
`endif

    // 3) six blocks back to back: the two excess results are dropped
    begin_burst();
    check("t3_clr_cnt", {48'd0, result_cnt}, 64'd0);
    check("t3_clr_sig", signature, 64'd0);
    issue(6);
    wait_done("t3_done_timeout", 100);
    repeat (60) @(negedge clk);
    check("t3_cnt", {48'd0, result_cnt}, 64'd4);
    check("t3_sig", signature, 64'h0000_0000_0000_000F);
    check("t3_done", {63'd0, done}, 64'd1);

    // 4) start pulse in RUN after two captures is ignored
    begin_burst();
    issue(4);
    wait_cnt("t4_cnt2_timeout", 16'd2, 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done_timeout", 100);
    check("t4_cnt", {48'd0, result_cnt}, 64'd4);
    check("t4_sig", signature, 64'h0000_0000_0000_000F);

    // 4b) top bit set on every result exercises the feedback path
    des_out = 64'h8000_0000_0000_0000;
    begin_burst();
    issue(4);
    wait_done("t4b_done_timeout", 100);
    check("t4b_sig", signature, 64'h8000_0000_0000_0007);
    @(negedge clk);
    check("t4b_led", {48'd0, led}, 64'h8007);
`ifdef DES3_MON_GOLDEN_EN
    check("t6_fail_bad", {62'd0, pass, fail}, 64'd1);
`else
    check("t6_pf_off2", {62'd0, pass, fail}, 64'd0);
`endif

    // 4c) des_out changes every cycle; the model checks the signature
    begin_burst();
    in_valid = 1'b1;
    for (int k = 0; k < 70 && !done; k++) begin
      if (k == 4) in_valid = 1'b0;
      des_out = 64'h0123_4567_89AB_CDEF ^ (64'(k) * 64'h0000_1111_0000_1111);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done("t4c_done_timeout", 100);
    check("t4c_cnt", {48'd0, result_cnt}, 64'd4);

    // 5) reset in mid-burst; the results still in flight are never captured
    des_out = 64'd1;
    begin_burst();
    issue(4);
    wait_cnt("t5_cnt2_timeout", 16'd2, 100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rst_cnt", {48'd0, result_cnt}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    begin_burst();
    repeat (100) @(negedge clk);
    check("t5_busy", {63'd0, busy}, 64'd1);
    check("t5_done", {63'd0, done}, 64'd0);
    check("t5_cnt",  {48'd0, result_cnt}, 64'd0);
    check("t5_sig",  signature, 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
